// File: rtl/vga_pkg.sv
// Shared VGA timing and VRAM geometry constants for the 640x480 display path.
package vga_pkg;

  localparam int H_TOTAL        = 800;
  localparam int V_TOTAL        = 524;
  localparam int H_ACTIVE       = 640;
  localparam int V_ACTIVE       = 480;
  localparam int WORDS_PER_LINE = 160;
  localparam int VRAM_WORDS     = 76800;
  localparam int ADR_W          = 17;

endpackage

// File: rtl/vram_fetch_addr.sv
// Display fetch slot detection and VRAM word address (line*160 + word).
// Purely combinational; evaluated on the current timing counters.
module vram_fetch_addr #(
  parameter int WORDS_PER_LINE = vga_pkg::WORDS_PER_LINE,
  parameter int ACTIVE_LINES   = vga_pkg::V_ACTIVE,
  parameter int ADR_W          = vga_pkg::ADR_W
) (
  input  logic [9:0]       h_cnt,
  input  logic [9:0]       v_cnt,
  output logic             slot,
  output logic [ADR_W-1:0] fetch_adr
);

  import vga_pkg::*;

  // Last in-line slot fetches the final word of the line; the slot four
  // clocks before the horizontal wrap prefetches word 0 of the next line.
  localparam logic [9:0] LAST_SLOT_H = 10'((WORDS_PER_LINE - 2) * 4);
  localparam logic [9:0] PREFETCH_H  = 10'(H_TOTAL - 4);
  localparam logic [9:0] LAST_LINE   = 10'(V_TOTAL - 1);
  localparam logic [9:0] LINES       = 10'(ACTIVE_LINES);

  logic [9:0] line;
  logic [9:0] next_line;
  logic [7:0] word;

  // Slot decode and address build; 160 = 128 + 32 so no multiplier is needed.
  always_comb begin
    slot      = 1'b0;
    line      = v_cnt;
    word      = 8'd0;
    next_line = (v_cnt == LAST_LINE) ? 10'd0 : v_cnt + 10'd1;
    if (h_cnt[1:0] == 2'd0 && h_cnt <= LAST_SLOT_H && v_cnt < LINES) begin
      slot = 1'b1;
      word = h_cnt[9:2] + 8'd1;
    end else if (h_cnt == PREFETCH_H && next_line < LINES) begin
      slot = 1'b1;
      line = next_line;
    end
    fetch_adr = (ADR_W'(line) << 7) + (ADR_W'(line) << 5) + ADR_W'(word);
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has absolute priority on its fixed
// slots, the host is granted on free cycles, and fetched words are shifted
// out as 4-bit pixels aligned with the registered timing outputs.
//
// Host handshake: hostReq is held (with hostWe/hostAdr/hostWrData stable)
// until a one-cycle hostAck pulse; the access is on the VRAM port in the ack
// cycle. A read returns hostRdData with a one-cycle hostRdValid two cycles
// after the ack. A grant is never made in a cycle that already shows hostAck,
// so back-to-back acks cannot happen and a held request is not double-served.
module vram_arbiter #(
  parameter int WORDS_PER_LINE = vga_pkg::WORDS_PER_LINE,
  parameter int ACTIVE_LINES   = vga_pkg::V_ACTIVE,
  parameter int ADR_W          = vga_pkg::ADR_W
) (
  input  logic             ckVideo,
  input  logic             resetN,
  input  logic [9:0]       adrHor,
  input  logic [9:0]       adrVer,
  input  logic             hostReq,
  input  logic             hostWe,
  input  logic [ADR_W-1:0] hostAdr,
  input  logic [15:0]      hostWrData,
  output logic             hostAck,
  output logic [15:0]      hostRdData,
  output logic             hostRdValid,
  output logic             vramEn,
  output logic             vramWe,
  output logic [ADR_W-1:0] vramAdr,
  output logic [15:0]      vramWrData,
  input  logic [15:0]      vramRdData,
  output logic [3:0]       pixColor,
  output logic             vblank,
  output logic             frameTick
);

  import vga_pkg::*;

  logic             slot;
  logic [ADR_W-1:0] fetch_adr;
  logic             grant;
  logic             in_range;
  logic             fetch_p1, fetch_p2;
  logic             rd_p1, rd_p2;
  logic             oor_p1, oor_p2;
  logic [15:0]      shadow_q;
  logic [15:0]      shift_q;

  vram_fetch_addr #(
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .ACTIVE_LINES   (ACTIVE_LINES),
    .ADR_W          (ADR_W)
  ) u_fetch (
    .h_cnt     (adrHor),
    .v_cnt     (adrVer),
    .slot      (slot),
    .fetch_adr (fetch_adr)
  );

  // Host wins only a cycle with no fetch slot and no ack already showing.
  always_comb begin
    in_range = (hostAdr < ADR_W'(VRAM_WORDS));
    grant    = hostReq && !slot && !hostAck;
  end

  // VRAM command register and host acknowledge.
  always_ff @(posedge ckVideo or negedge resetN) begin
    if (!resetN) begin
      hostAck    <= 1'b0;
      vramEn     <= 1'b0;
      vramWe     <= 1'b0;
      vramAdr    <= '0;
      vramWrData <= 16'd0;
    end else begin
      hostAck <= grant;
      if (slot) begin
        vramEn  <= 1'b1;
        vramWe  <= 1'b0;
        vramAdr <= fetch_adr;
      end else if (grant) begin
        // Out-of-range addresses are acked but never reach the macro.
        vramEn     <= in_range;
        vramWe     <= hostWe && in_range;
        vramAdr    <= hostAdr;
        vramWrData <= hostWrData;
      end else begin
        vramEn <= 1'b0;
        vramWe <= 1'b0;
      end
    end
  end

  // Read-return pipeline: tags follow the access until the data arrives.
  always_ff @(posedge ckVideo or negedge resetN) begin
    if (!resetN) begin
      fetch_p1    <= 1'b0;
      fetch_p2    <= 1'b0;
      rd_p1       <= 1'b0;
      rd_p2       <= 1'b0;
      oor_p1      <= 1'b0;
      oor_p2      <= 1'b0;
      shadow_q    <= 16'd0;
      hostRdValid <= 1'b0;
      hostRdData  <= 16'd0;
    end else begin
      fetch_p1    <= slot;
      fetch_p2    <= fetch_p1;
      rd_p1       <= grant && !hostWe;
      rd_p2       <= rd_p1;
      oor_p1      <= grant && !in_range;
      oor_p2      <= oor_p1;
      hostRdValid <= rd_p2;
      if (fetch_p2) shadow_q <= vramRdData;
      if (rd_p2) hostRdData <= oor_p2 ? 16'd0 : vramRdData;
    end
  end

  // Pixel shifter plus registered blanking and frame marker.
  always_ff @(posedge ckVideo or negedge resetN) begin
    if (!resetN) begin
      shift_q   <= 16'd0;
      pixColor  <= 4'd0;
      vblank    <= 1'b0;
      frameTick <= 1'b0;
    end else begin
      if (adrHor[1:0] == 2'd3) shift_q <= shadow_q;
      pixColor  <= shift_q[{adrHor[1:0], 2'b00} +: 4];
      vblank    <= (adrVer >= 10'(ACTIVE_LINES));
      frameTick <= (adrHor == 10'd0) && (adrVer == 10'd0);
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter with a behavioural synchronous VRAM.
module tb_vram_arbiter;

  localparam int ADR_W = vga_pkg::ADR_W;
  localparam int WORDS = vga_pkg::VRAM_WORDS;

  // Clock / reset and DUT signals
  logic             ckVideo = 1'b0;
  logic             resetN;
  logic [9:0]       adrHor, adrVer;
  logic             hostReq, hostWe;
  logic [ADR_W-1:0] hostAdr;
  logic [15:0]      hostWrData;
  logic             hostAck, hostRdValid;
  logic [15:0]      hostRdData;
  logic             vramEn, vramWe;
  logic [ADR_W-1:0] vramAdr;
  logic [15:0]      vramWrData;
  logic [15:0]      vramRdData = 16'd0;
  logic [3:0]       pixColor;
  logic             vblank, frameTick;

  logic [15:0] mem [0:WORDS-1];

  int checks   = 0;
  int failures = 0;
  int ack_cnt;
  int val_cnt;

  always #5 ckVideo = ~ckVideo;

  vram_arbiter dut (
    .ckVideo     (ckVideo),
    .resetN      (resetN),
    .adrHor      (adrHor),
    .adrVer      (adrVer),
    .hostReq     (hostReq),
    .hostWe      (hostWe),
    .hostAdr     (hostAdr),
    .hostWrData  (hostWrData),
    .hostAck     (hostAck),
    .hostRdData  (hostRdData),
    .hostRdValid (hostRdValid),
    .vramEn      (vramEn),
    .vramWe      (vramWe),
    .vramAdr     (vramAdr),
    .vramWrData  (vramWrData),
    .vramRdData  (vramRdData),
    .pixColor    (pixColor),
    .vblank      (vblank),
    .frameTick   (frameTick)
  );

  // Synchronous single-port VRAM model: read data appears the cycle after vramEn.
  always @(posedge ckVideo) begin
    if (vramEn) begin
      if (vramWe) mem[vramAdr] <= vramWrData;
      else        vramRdData   <= mem[vramAdr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: outputs are sampled and inputs changed 1 time unit after the edge.
  task automatic tick();
    @(posedge ckVideo);
    #1;
    if (adrHor == 10'd799) begin
      adrHor = 10'd0;
      adrVer = (adrVer == 10'd523) ? 10'd0 : adrVer + 10'd1;
    end else begin
      adrHor = adrHor + 10'd1;
    end
  endtask

  task automatic run_to(input logic [9:0] v, input logic [9:0] h);
    for (int i = 0; i < 450000 && !(adrVer == v && adrHor == h); i++) tick();
  endtask

  task automatic check_zero(input string where);
    check({where, "_hostAck"},     32'(hostAck),     32'd0);
    check({where, "_hostRdValid"}, 32'(hostRdValid), 32'd0);
    check({where, "_hostRdData"},  32'(hostRdData),  32'd0);
    check({where, "_vramEn"},      32'(vramEn),      32'd0);
    check({where, "_vramWe"},      32'(vramWe),      32'd0);
    check({where, "_vramAdr"},     32'(vramAdr),     32'd0);
    check({where, "_vramWrData"},  32'(vramWrData),  32'd0);
    check({where, "_pixColor"},    32'(pixColor),    32'd0);
    check({where, "_vblank"},      32'(vblank),      32'd0);
    check({where, "_frameTick"},   32'(frameTick),   32'd0);
  endtask

  // Pixel expected in the cycle after adrHor = x, for lines whose base address is a multiple of 16.
  function automatic logic [31:0] pix_exp(input logic [9:0] h);
    logic [9:0] x;
    x = h - 10'd1;
    return 32'((x >> 2) & 10'h00F);
  endfunction

  initial begin
    for (int k = 0; k < WORDS; k++) mem[k] = {4{k[3:0]}};
    resetN     = 1'b0;
    hostReq    = 1'b0;
    hostWe     = 1'b0;
    hostAdr    = '0;
    hostWrData = 16'd0;
    adrVer     = 10'd523;
    adrHor     = 10'd780;

    // Reset state
    tick(); tick(); tick();
    check_zero("reset");
    resetN = 1'b1;

    // Frame start markers and line 0 pixels (word 0 prefetched at 796 of line 523)
    run_to(10'd0, 10'd0);
    check("vblank_line523", 32'(vblank), 32'd1);
    check("frameTick_pre", 32'(frameTick), 32'd0);
    tick();
    check("frameTick_pulse", 32'(frameTick), 32'd1);
    check("vblank_line0", 32'(vblank), 32'd0);
    while (adrVer == 10'd0 && adrHor <= 10'd640) begin
      check("pix_line0", 32'(pixColor), pix_exp(adrHor));
      if (adrHor == 10'd2) check("frameTick_once", 32'(frameTick), 32'd0);
      tick();
    end

    // Host write raised on a slot cycle: deferred one cycle
    run_to(10'd1, 10'd8);
    hostReq = 1'b1; hostWe = 1'b1; hostAdr = 17'd5; hostWrData = 16'hABCD;
    tick();
    check("wr_no_ack_9", 32'(hostAck), 32'd0);
    tick();
    check("wr_ack_10", 32'(hostAck), 32'd1);
    check("wr_vramEn", 32'(vramEn), 32'd1);
    check("wr_vramWe", 32'(vramWe), 32'd1);
    check("wr_vramAdr", 32'(vramAdr), 32'd5);
    check("wr_vramWrData", 32'(vramWrData), 32'hABCD);
    hostReq = 1'b0;
    tick();
    check("wr_ack_drop", 32'(hostAck), 32'd0);

    // Host read of the written word
    run_to(10'd2, 10'd1);
    hostReq = 1'b1; hostWe = 1'b0; hostAdr = 17'd5;
    tick();
    check("rd_ack_2", 32'(hostAck), 32'd1);
    check("rd_vramEn", 32'(vramEn), 32'd1);
    check("rd_vramWe", 32'(vramWe), 32'd0);
    check("rd_vramAdr", 32'(vramAdr), 32'd5);
    hostReq = 1'b0;
    tick();
    check("rd_valid_3", 32'(hostRdValid), 32'd0);
    tick();
    check("rd_valid_4", 32'(hostRdValid), 32'd1);
    check("rd_data_4", 32'(hostRdData), 32'hABCD);
    tick();
    check("rd_valid_5", 32'(hostRdValid), 32'd0);

    // Prefetch of line 10 word 0 at adrHor=796 of line 9
    run_to(10'd9, 10'd797);
    check("prefetch_en", 32'(vramEn), 32'd1);
    check("prefetch_we", 32'(vramWe), 32'd0);
    check("prefetch_adr", 32'(vramAdr), 32'd1600);

    // Host read request held across line 10 (adr 100 holds 16'h4444)
    run_to(10'd10, 10'd0);
    hostReq = 1'b1; hostWe = 1'b0; hostAdr = 17'd100;
    ack_cnt = 0;
    val_cnt = 0;
    tick();
    while (adrVer == 10'd10 && adrHor <= 10'd645) begin
      check("held_ack_pattern", 32'(hostAck),
            32'(adrHor[0] == 1'b0 && adrHor >= 10'd2 && adrHor <= 10'd640));
      if (hostAck) ack_cnt++;
      if (hostRdValid) begin
        val_cnt++;
        check("held_rd_data", 32'(hostRdData), 32'h4444);
      end
      if (adrHor <= 10'd640) check("pix_line10", 32'(pixColor), pix_exp(adrHor));
      if (adrHor == 10'd5) begin
        check("fetch_en_5", 32'(vramEn), 32'd1);
        check("fetch_we_5", 32'(vramWe), 32'd0);
        check("fetch_adr_5", 32'(vramAdr), 32'd1602);
      end
      if (adrHor == 10'd640) hostReq = 1'b0;
      tick();
    end
    check("held_ack_count", 32'(ack_cnt), 32'd320);
    check("held_valid_count", 32'(val_cnt), 32'd320);

    // Out-of-range write and read
    run_to(10'd11, 10'd1);
    hostReq = 1'b1; hostWe = 1'b1; hostAdr = 17'd76800; hostWrData = 16'h1234;
    tick();
    check("oor_wr_ack", 32'(hostAck), 32'd1);
    check("oor_wr_vramEn", 32'(vramEn), 32'd0);
    check("oor_wr_vramWe", 32'(vramWe), 32'd0);
    hostReq = 1'b0;
    run_to(10'd11, 10'd5);
    hostReq = 1'b1; hostWe = 1'b0; hostAdr = 17'd80000;
    tick();
    check("oor_rd_ack", 32'(hostAck), 32'd1);
    check("oor_rd_vramEn", 32'(vramEn), 32'd0);
    hostReq = 1'b0;
    tick();
    tick();
    check("oor_rd_valid", 32'(hostRdValid), 32'd1);
    check("oor_rd_data", 32'(hostRdData), 32'd0);

    // Reset asserted with a read in flight
    run_to(10'd12, 10'd298);
    hostReq = 1'b1; hostWe = 1'b0; hostAdr = 17'd5;
    tick();
    check("midrst_ack", 32'(hostAck), 32'd1);
    hostReq = 1'b0;
    tick();
    resetN = 1'b0;
    #1;
    check_zero("midrst");
    tick();
    tick();
    resetN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst_valid", 32'(hostRdValid), 32'd0);
      check("post_rst_ack", 32'(hostAck), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
